axi_xbar_arbiter: RTL

AXI_XBAR_ARBITER -- requirements
Module: axi_xbar_arbiter

---
 rtl/axi_xbar_arbiter.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/axi_xbar_arbiter.sv
// Two-master AXI crossbar arbiter: independent round-robin write and read grant FSMs with
// completed-transaction counters. Optional per-path watchdog enabled by AXI_XBAR_ARB_TIMEOUT_EN.
module axi_xbar_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 m0_aw_req,
    input  logic                 m1_aw_req,
    input  logic                 m0_ar_req,
    input  logic                 m1_ar_req,
    input  logic                 aw_hs,
    input  logic                 w_last_hs,
    input  logic                 b_hs,
    input  logic                 ar_hs,
    input  logic                 r_last_hs,
    output logic                 wr_gnt_valid,
    output logic                 wr_gnt_m1,
    output logic                 rd_gnt_valid,
    output logic                 rd_gnt_m1,
    output logic [CNT_WIDTH-1:0] wr_txn_cnt,
    output logic [CNT_WIDTH-1:0] rd_txn_cnt,
    input  logic                 err_clr,
    output logic                 err_timeout
);

    typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;

    // On a tie the master not served last wins; a lone requester always wins.
    function automatic logic pick_m1(input logic req0, input logic req1, input logic last_m1);
        if (req0 && req1) begin
            return !last_m1;
        end
        return req1;
    endfunction

    wr_state_t wr_state, wr_state_n;
    rd_state_t rd_state, rd_state_n;
    logic      wr_m1, wr_m1_n, rd_m1, rd_m1_n;
    logic      wr_last, wr_last_n, rd_last, rd_last_n;
    logic      aw_seen, aw_seen_n, wl_seen, wl_seen_n;
    logic      wr_done, rd_done;
    logic      wr_expected, rd_expected;
    logic      wr_timeout, rd_timeout;

    always_comb begin
        wr_expected = 1'b0;
        case (wr_state)
            W_XFER:  wr_expected = aw_hs | w_last_hs;
            W_RESP:  wr_expected = b_hs;
            default: wr_expected = 1'b0;
        endcase
    end

    always_comb begin
        rd_expected = 1'b0;
        case (rd_state)
            R_ADDR:  rd_expected = ar_hs;
            R_DATA:  rd_expected = r_last_hs;
            default: rd_expected = 1'b0;
        endcase
    end

`ifdef AXI_XBAR_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wr_wd, rd_wd;

    // A path times out on the cycle its stall count would reach TIMEOUT_CYCLES.
    assign wr_timeout = (wr_state != W_IDLE) && !wr_expected && (wr_wd == WD_W'(TIMEOUT_CYCLES - 1));
    assign rd_timeout = (rd_state != R_IDLE) && !rd_expected && (rd_wd == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_wd       <= '0;
            rd_wd       <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (wr_state == W_IDLE || wr_expected || wr_timeout) begin
                wr_wd <= '0;
            end else begin
                wr_wd <= wr_wd + WD_W'(1);
            end
            if (rd_state == R_IDLE || rd_expected || rd_timeout) begin
                rd_wd <= '0;
            end else begin
                rd_wd <= rd_wd + WD_W'(1);
            end
            if (wr_timeout || rd_timeout) begin
                err_timeout <= 1'b1;
            end else if (err_clr) begin
                err_timeout <= 1'b0;
            end
        end
    end
`else
    logic unused_cfg;

    assign wr_timeout  = 1'b0;
    assign rd_timeout  = 1'b0;
    assign err_timeout = 1'b0;
    assign unused_cfg  = err_clr ^ (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        wr_state_n = wr_state;
        wr_m1_n    = wr_m1;
        wr_last_n  = wr_last;
        aw_seen_n  = aw_seen;
        wl_seen_n  = wl_seen;
        wr_done    = 1'b0;
        case (wr_state)
            W_IDLE: begin
                if (m0_aw_req || m1_aw_req) begin
                    wr_state_n = W_XFER;
                    wr_m1_n    = pick_m1(m0_aw_req, m1_aw_req, wr_last);
                end
            end
            W_XFER: begin
                aw_seen_n = aw_seen | aw_hs;
                wl_seen_n = wl_seen | w_last_hs;
                if (aw_seen_n && wl_seen_n) begin
                    wr_state_n = W_RESP;
                    aw_seen_n  = 1'b0;
                    wl_seen_n  = 1'b0;
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    wr_state_n = W_IDLE;
                    wr_last_n  = wr_m1;
                    wr_done    = 1'b1;
                end
            end
            default: begin
                wr_state_n = W_IDLE;
                aw_seen_n  = 1'b0;
                wl_seen_n  = 1'b0;
            end
        endcase
        if (wr_timeout) begin
            wr_state_n = W_IDLE;
            wr_last_n  = wr_m1;
            aw_seen_n  = 1'b0;
            wl_seen_n  = 1'b0;
        end
    end

    always_comb begin
        rd_state_n = rd_state;
        rd_m1_n    = rd_m1;
        rd_last_n  = rd_last;
        rd_done    = 1'b0;
        case (rd_state)
            R_IDLE: begin
                if (m0_ar_req || m1_ar_req) begin
                    rd_state_n = R_ADDR;
                    rd_m1_n    = pick_m1(m0_ar_req, m1_ar_req, rd_last);
                end
            end
            R_ADDR: begin
                if (ar_hs) begin
                    rd_state_n = R_DATA;
                end
            end
            R_DATA: begin
                if (r_last_hs) begin
                    rd_state_n = R_IDLE;
                    rd_last_n  = rd_m1;
                    rd_done    = 1'b1;
                end
            end
            default: rd_state_n = R_IDLE;
        endcase
        if (rd_timeout) begin
            rd_state_n = R_IDLE;
            rd_last_n  = rd_m1;
        end
    end

    // Last-served pointers reset to m1 so the first tie on each path goes to m0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state   <= W_IDLE;
            rd_state   <= R_IDLE;
            wr_m1      <= 1'b0;
            rd_m1      <= 1'b0;
            wr_last    <= 1'b1;
            rd_last    <= 1'b1;
            aw_seen    <= 1'b0;
            wl_seen    <= 1'b0;
            wr_txn_cnt <= '0;
            rd_txn_cnt <= '0;
        end else begin
            wr_state <= wr_state_n;
            rd_state <= rd_state_n;
            wr_m1    <= wr_m1_n;
            rd_m1    <= rd_m1_n;
            wr_last  <= wr_last_n;
            rd_last  <= rd_last_n;
            aw_seen  <= aw_seen_n;
            wl_seen  <= wl_seen_n;
            if (wr_done) begin
                wr_txn_cnt <= wr_txn_cnt + CNT_WIDTH'(1);
            end
            if (rd_done) begin
                rd_txn_cnt <= rd_txn_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign wr_gnt_valid = (wr_state != W_IDLE);
    assign rd_gnt_valid = (rd_state != R_IDLE);
    assign wr_gnt_m1    = wr_m1;
    assign rd_gnt_m1    = rd_m1;

endmodule
